pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-005 redirect_pc  input  32  redirect target address.
REQ-006 stall  input  1  decode stage cannot accept the held instruction.
REQ-007 imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 imem_req_addr  output  32  fetch address (current PC).
REQ-009 imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 imem_rsp_valid  input  1  instruction word returned.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  held instruction valid to decode.
REQ-013 inst_pc  output  32  address of held instruction.
REQ-014 inst_npc  output  32  inst_pc + 4, modulo 2^32.
REQ-015 inst_data  output  32  held instruction word.
REQ-016 fetch_misalign  output  1  present only with FETCH_ALIGN_CHECK_EN.

Function
REQ-017 States: BOOT, REQ, WAIT, HOLD (plus FAULT with macro); internal pc register and kill flag.
REQ-018 BOOT: imem_req_valid=0; unconditionally to REQ next cycle.
REQ-019 REQ: imem_req_valid = ~redirect_valid, imem_req_addr = pc; on imem_req_valid & imem_req_ready -> WAIT.
REQ-020 REQ with redirect_valid: pc <= redirect_pc, stay REQ, no request issued that cycle.
REQ-021 WAIT: imem_req_valid=0; on imem_rsp_valid & ~kill & ~redirect_valid: inst_data <= imem_rsp_data, inst_pc <= pc, inst_valid <= 1, pc <= pc+4, -> HOLD.
REQ-022 WAIT with redirect_valid and no response: pc <= redirect_pc, kill <= 1, stay WAIT.
REQ-023 WAIT with imem_rsp_valid and (kill or redirect_valid): response discarded, kill <= 0, pc <= redirect_pc if redirect_valid, -> REQ.
REQ-024 HOLD: redirect_valid has priority: inst_valid <= 0, pc <= redirect_pc, -> REQ.
REQ-025 HOLD without redirect: stall=1 holds all inst_* stable; stall=0 consumes: inst_valid <= 0, -> REQ.
REQ-026 inst_npc combinational from inst_pc; pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-027 At most one outstanding memory request; responses in REQ/HOLD/BOOT ignored.
REQ-028 Redirect in BOOT: pc <= redirect_pc, -> REQ.

Reset
REQ-029 rst_n=0 asynchronously: state BOOT, pc RESET_PC, kill 0, inst_valid 0, inst_pc 0, inst_data 0, imem_req_valid 0, fetch_misalign 0.
REQ-030 Reset mid-WAIT abandons the outstanding request; its late response is ignored.

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misalign sticky 1, enters FAULT (no requests, inst_valid 0) until reset; redirect ignored otherwise.
REQ-032 Macro undefined: port fetch_misalign absent; redirect_pc[1:0] forced to 2'b00 on load.

Verification
REQ-033 Reset release, ready=1, rsp one cycle after accept with 32'h2400_0001 -> first req addr 32'h0000_3000; inst_valid with inst_pc 32'h3000, inst_npc 32'h3004.
REQ-034 stall=1 for 5 cycles in HOLD -> inst_* unchanged, no request; stall=0 -> next req addr 32'h0000_3004.
REQ-035 redirect to 32'h0000_4000 during WAIT, rsp arrives 2 cycles later -> response dropped, inst_valid stays 0, next req addr 32'h0000_4000.
REQ-036 redirect to 32'h0000_5000 same cycle as rsp_valid -> dropped, next req 32'h0000_5000.
REQ-037 pc=32'hFFFF_FFFC fetched -> inst_npc 32'h0, next req addr 32'h0.
REQ-038 With macro, redirect to 32'h0000_4002 -> fetch_misalign=1, no further imem_req_valid until rst_n=0; without macro -> next req 32'h0000_4000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, single-entry instruction hold.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
//
// state | meaning
// BOOT  | first cycle out of reset, no request
// REQ   | present pc to instruction memory
// WAIT  | request accepted, waiting for the response (kill drops a stale one)
// HOLD  | instruction held for decode until consumed or redirected
// FAULT | misaligned redirect seen, fetch stopped until reset (FETCH_ALIGN_CHECK_EN only)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_npc,
  output logic [31:0] inst_data
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    ST_FAULT = 3'd4
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic        inst_valid_q, inst_valid_nxt;
  logic [31:0] inst_pc_q, inst_pc_nxt;
  logic [31:0] inst_data_q, inst_data_nxt;
  logic        req_valid;
  logic [31:0] redirect_target;

  // Low address bits are dropped so the pc can never become misaligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_nxt;
  logic redir_bad;
  assign redir_bad      = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_BOOT;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= 32'h0;
      inst_data_q  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      kill         <= kill_nxt;
      inst_valid_q <= inst_valid_nxt;
      inst_pc_q    <= inst_pc_nxt;
      inst_data_q  <= inst_data_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q   <= misalign_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    kill_nxt       = kill;
    inst_valid_nxt = inst_valid_q;
    inst_pc_nxt    = inst_pc_q;
    inst_data_nxt  = inst_data_q;
    req_valid      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_nxt   = misalign_q;
`endif
    case (state)
      ST_BOOT: begin
        state_nxt = ST_REQ;
        if (redirect_valid) pc_nxt = redirect_target;
      end
      ST_REQ: begin
        req_valid = ~redirect_valid;
        if (redirect_valid) pc_nxt = redirect_target;
        else if (imem_req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill || redirect_valid) begin
            kill_nxt  = 1'b0;
            state_nxt = ST_REQ;
            if (redirect_valid) pc_nxt = redirect_target;
          end else begin
            inst_data_nxt  = imem_rsp_data;
            inst_pc_nxt    = pc;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc + 32'd4;
            state_nxt      = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // Request already in flight: remember to drop its response.
          pc_nxt   = redirect_target;
          kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          inst_valid_nxt = 1'b0;
          pc_nxt         = redirect_target;
          state_nxt      = ST_REQ;
        end else if (!stall) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = ST_REQ;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT: begin
        inst_valid_nxt = 1'b0;
      end
`endif
      default: state_nxt = ST_BOOT;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (redir_bad && state != ST_FAULT) begin
      state_nxt      = ST_FAULT;
      pc_nxt         = pc;
      kill_nxt       = 1'b0;
      inst_valid_nxt = 1'b0;
      req_valid      = 1'b0;
      misalign_nxt   = 1'b1;
    end
`endif
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst_pc        = inst_pc_q;
  assign inst_npc       = inst_pc_q + 32'd4;
  assign inst_data      = inst_data_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then randomized traffic against a transaction-level model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_npc;
  logic [31:0] inst_data;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_npc       (inst_npc),
    .inst_data      (inst_data)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch pipeline described as flags, not as FSM states.
  bit          m_boot, m_out, m_stale, m_held, m_fault, m_accept;
  logic [31:0] m_pc, m_held_pc, m_held_data;

  function automatic logic [31:0] aligned(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_boot = 1; m_out = 0; m_stale = 0; m_held = 0; m_fault = 0; m_accept = 0;
    m_pc = 32'h0000_3000; m_held_pc = 32'h0; m_held_data = 32'h0;
  endtask

  task automatic model_step();
    if (m_fault) return;
    if (ALIGN_EN && redirect_valid && redirect_pc[1:0] != 2'b00) begin
      m_fault = 1; m_held = 0; m_out = 0; m_stale = 0;
    end else if (m_boot) begin
      m_boot = 0;
      if (redirect_valid) m_pc = aligned(redirect_pc);
    end else if (m_held) begin
      if (redirect_valid) begin m_held = 0; m_pc = aligned(redirect_pc); end
      else if (!stall) m_held = 0;
    end else if (m_out) begin
      if (imem_rsp_valid) begin
        m_out = 0;
        if (!m_stale && !redirect_valid) begin
          m_held = 1; m_held_pc = m_pc; m_held_data = imem_rsp_data; m_pc = m_pc + 32'd4;
        end else begin
          m_stale = 0;
          if (redirect_valid) m_pc = aligned(redirect_pc);
        end
      end else if (redirect_valid) begin
        m_pc = aligned(redirect_pc); m_stale = 1;
      end
    end else begin
      if (redirect_valid) m_pc = aligned(redirect_pc);
      else if (imem_req_ready) m_out = 1;
    end
  endtask

  task automatic drive(input bit rv, input logic [31:0] rpc, input bit st, input bit rdy,
                       input bit rspv, input logic [31:0] rspd);
    bit exp_req;
    redirect_valid = rv; redirect_pc = rpc; stall = st;
    imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = rspd;
    #1;
    exp_req  = !m_boot && !m_out && !m_held && !m_fault && !rv;
    m_accept = exp_req && rdy;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_held));
    if (m_held) begin
      chk("inst_pc", inst_pc, m_held_pc);
      chk("inst_npc", inst_npc, m_held_pc + 32'd4);
      chk("inst_data", inst_data, m_held_data);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    chk("fetch_misalign", 32'(fetch_misalign), 32'(m_fault));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit st, input bit rdy,
                      input bit rspv, input logic [31:0] rspd);
    drive(rv, rpc, st, rdy, rspv, rspd);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 0; stall = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  bit          mem_pend;
  int unsigned mem_dly;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Boot and first fetch.
    step(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0000_3000);
    tick();
    step(0, 0, 0, 1, 1, 32'h2400_0001);
    drive(0, 0, 1, 1, 0, 0);
    chk("first_inst_pc", inst_pc, 32'h0000_3000);
    chk("first_inst_npc", inst_npc, 32'h0000_3004);
    chk("first_inst_data", inst_data, 32'h2400_0001);
    tick();

    // Stall holds the instruction, then consume.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 1, 32'hDEAD_0000 + 32'(i));
      chk("stall_no_req", 32'(imem_req_valid), 32'h0);
      chk("stall_inst_pc", inst_pc, 32'h0000_3000);
      tick();
    end
    step(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("after_stall_addr", imem_req_addr, 32'h0000_3004);
    tick();

    // Redirect while waiting; late response dropped.
    step(1, 32'h0000_4000, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h1111_1111);
    drive(0, 0, 0, 1, 0, 0);
    chk("kill_inst_valid", 32'(inst_valid), 32'h0);
    chk("kill_next_addr", imem_req_addr, 32'h0000_4000);
    tick();

    // Redirect coincident with response.
    step(1, 32'h0000_5000, 0, 1, 1, 32'h2222_2222);
    drive(0, 0, 0, 1, 0, 0);
    chk("coinc_inst_valid", 32'(inst_valid), 32'h0);
    chk("coinc_next_addr", imem_req_addr, 32'h0000_5000);
    tick();
    step(0, 0, 0, 1, 1, 32'h3333_3333);
    step(0, 0, 0, 1, 0, 0);

    // Wrap at the top of the address space.
    step(1, 32'hFFFF_FFFC, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    step(0, 0, 0, 1, 1, 32'h4444_4444);
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_inst_npc", inst_npc, 32'h0000_0000);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    tick();

    // Reset mid-wait; late response arrives in BOOT and REQ and is ignored.
    do_reset();
    step(0, 0, 0, 0, 1, 32'h5555_5555);
    step(0, 0, 0, 0, 1, 32'h5555_5555);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("late_rsp_inst_valid", 32'(inst_valid), 32'h0);

    // Misaligned redirect.
    step(0, 0, 0, 1, 1, 32'h6666_6666);
    step(1, 32'h0000_4002, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_set", 32'(fetch_misalign), 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      chk("fault_no_req", 32'(imem_req_valid), 32'h0);
      tick();
    end
`else
    chk("misalign_addr", imem_req_addr, 32'h0000_4000);
    tick();
`endif
    do_reset();

    // Randomized traffic with a one-deep memory model.
    mem_pend = 0; mem_dly = 0;
    for (int c = 0; c < 4000; c++) begin
      bit          rv, st, rdy, rspv;
      logic [31:0] rpc, rspd;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        mem_pend = 0;
        continue;
      end
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFFC;
      if (ALIGN_EN) rpc = aligned(rpc);
      st   = ($urandom_range(0, 2) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      rspd = $urandom();
      rspv = mem_pend ? (mem_dly == 0) : ($urandom_range(0, 7) == 0);
      drive(rv, rpc, st, rdy, rspv, rspd);
      tick();
      if (mem_pend) begin
        if (rspv) mem_pend = 0;
        else mem_dly--;
      end
      if (m_accept) begin
        mem_pend = 1;
        mem_dly  = $urandom_range(0, 3);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
